sum_accumulator: RTL
====================

# sum_accumulator

Downstream consumer of the structural adder's `sum` output. It accumulates a programmable batch of adder results into a wide accumulator. Each completed batch total is presented on a valid/ready output port with per-batch overflow status. Because the adder has no stall path, a separate result register lets accumulation continue while a total waits to be read. Results that cannot be stored are dropped and flagged.

## Interface
Parameters:
- `N`, 32, adder operand width; `sum_in` is N+1 bits
- `ACC_W`, 48, accumulator and result width; must be ≥ N+1
- `BATCH_W`, 8, width of the batch length and sample counter

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `sum_in` in N+1: adder result, zero-extended to ACC_W
- `sum_valid` in 1: `sum_in` is a sample this cycle
- `batch_len` in BATCH_W: samples per batch; 0 is treated as 1
- `clr` in 1: synchronous clear
- `acc_out` out ACC_W: batch total
- `acc_valid` out 1: `acc_out` holds an unread total
- `acc_ready` in 1: consumer accepts `acc_out`
- `acc_ovf` out 1: the total in `acc_out` overflowed ACC_W
- `overrun` out 1: sticky; a completed total was dropped
- `sample_count` out BATCH_W: samples accepted in the current batch

## Operation
- **Reset:** while `rst_n` is low, all internal and output registers are 0. The accumulator, counter, `acc_out`, `acc_valid`, `acc_ovf` and `overrun` are all 0.
- **Batch length latch:** `batch_len` is sampled into `len_q` on the first accepted sample of a batch (counter = 0). Changes mid-batch do not affect the batch in progress.
- **Accepted sample, not last** (counter < len_q−1): `acc <= acc + sum_in`, counter increments, and `ovf_q` ORs in the carry out of the add.
- **Accepted sample, last** (counter = len_q−1):
  - The final total is `acc + sum_in`; its flag is `ovf_q` OR the carry of this add.
  - Accumulator, counter and `ovf_q` return to 0.
  - If the result slot is free or is being consumed this cycle (`acc_valid` = 0, or `acc_valid` and `acc_ready`), the total loads into `acc_out`, the flag into `acc_ovf`, and `acc_valid` goes to 1.
  - Otherwise `acc_out` and `acc_ovf` are unchanged and `overrun` is set to 1.
- **Output handshake:**
  - A transfer occurs on any edge where `acc_valid` and `acc_ready` are both 1.
  - After a transfer `acc_valid` falls to 0, unless a new total loads on the same edge; then it stays 1 with the new data.
  - `acc_out` is stable while `acc_valid` = 1 and no transfer occurs.
- **Overflow arithmetic:** the accumulator adds modulo 2^ACC_W; see Configuration for saturation.
- **`clr`:** highest priority below reset. It zeroes the accumulator, counter, `ovf_q`, `acc_valid` and `overrun`. A sample presented in the same cycle is discarded. `acc_out` and `acc_ovf` keep their values.
- **`sample_count`:** equals the registered counter.

## Timing
- Latency: the last sample is accepted at edge k, and `acc_valid`/`acc_out` update at edge k (visible in cycle k+1).
- Throughput: one sample per cycle with no bubbles, including across batch boundaries.
- With batch length 1 and `acc_ready` held high, a new total is presented every cycle.
- Reset mid-batch: the partial accumulation is lost and the next sample starts a new batch.
- `overrun` stays 1 until `clr` or reset.

## Configuration
- **`SUM_ACC_SATURATE_EN` defined:** any add that carries out of ACC_W clamps the accumulator to all ones. It stays clamped for the rest of the batch, and `acc_ovf` is 1 for that batch.
- **`SUM_ACC_SATURATE_EN` undefined:** the accumulator wraps modulo 2^ACC_W, and `acc_ovf` still reports the carry.

## Test plan
- **Basic batch:** `batch_len`=4, `acc_ready`=1, samples 2000, 4000, 6000, 8000 on consecutive cycles. Required: `acc_out`=20000 with `acc_valid`=1 for one cycle, one cycle after the 4th sample; `sample_count` sequence 1, 2, 3, 0.
- **Overrun:** `batch_len`=1, `acc_ready`=0, samples 2000 then 4000. Required: `acc_out` stays 2000, `acc_valid`=1, `overrun`=1. Then raise `acc_ready` for one cycle: `acc_valid` goes to 0.
- **Back-to-back with simultaneous consume and load:** `batch_len`=1, `acc_ready`=1, samples 1000, 2000, 3000 on consecutive cycles. Required: `acc_valid` stays 1 for three cycles with `acc_out` = 1000, 2000, 3000, and `overrun`=0.
- **Overflow:** parameters N=32, ACC_W=34, `batch_len`=3, three samples of 0x1_FFFF_FFFF.
  - Without `SUM_ACC_SATURATE_EN`: `acc_out`=0x1_FFFF_FFFD and `acc_ovf`=1.
  - With `SUM_ACC_SATURATE_EN`: `acc_out`=0x3_FFFF_FFFF and `acc_ovf`=1.
- **Reset mid-batch:** `batch_len`=4, two samples of 1000, then `rst_n` low for 3 cycles. Required: all outputs 0 while in reset. Then four samples of 1000 give `acc_out`=4000.
- **Zero length and `clr`:** `batch_len`=0, one sample of 500: `acc_out`=500. Then `batch_len`=4 with 3 samples and `clr` coincident with a 4th: required `sample_count`=0, `acc_valid`=0, `acc_out` still 500, `overrun`=0.

Source files
------------

// File: rtl/sum_accumulator.sv
// Batch accumulator for adder results with a decoupled valid/ready result slot.
// Define SUM_ACC_SATURATE_EN to clamp the accumulator on carry-out instead of wrapping.
module sum_accumulator #(
  parameter int N       = 32,
  parameter int ACC_W   = 48,
  parameter int BATCH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N:0]         sum_in,
  input  logic               sum_valid,
  input  logic [BATCH_W-1:0] batch_len,
  input  logic               clr,
  output logic [ACC_W-1:0]   acc_out,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic               acc_ovf,
  output logic               overrun,
  output logic [BATCH_W-1:0] sample_count
);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   out_q, out_d;
  logic [BATCH_W-1:0] cnt_q, cnt_d;
  logic [BATCH_W-1:0] len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               aovf_q, aovf_d;
  logic               overrun_q, overrun_d;

  logic [ACC_W-1:0]   sum_ext;
  logic [ACC_W-1:0]   add_res;
  logic [ACC_W-1:0]   add_val;
  logic               carry;
  logic               batch_ovf;
  logic [BATCH_W-1:0] cur_len;
  logic               is_last;
  logic               xfer;
  logic               slot_free;

  always_comb begin
    sum_ext            = ACC_W'(sum_in);
    {carry, add_res}   = {1'b0, acc_q} + {1'b0, sum_ext};
`ifdef SUM_ACC_SATURATE_EN
    add_val            = carry ? '1 : add_res;
`else
    add_val            = add_res;
`endif
    batch_ovf          = ovf_q | carry;
    // The first sample of a batch uses the live length; later samples use the latched one.
    if (cnt_q == '0)
      cur_len = (batch_len == '0) ? BATCH_W'(1) : batch_len;
    else
      cur_len = len_q;
    is_last            = (cnt_q == (cur_len - BATCH_W'(1)));
    xfer               = valid_q & acc_ready;
    slot_free          = ~valid_q | acc_ready;
  end

  always_comb begin
    acc_d     = acc_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    aovf_d    = aovf_q;
    overrun_d = overrun_q;

    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (xfer)
        valid_d = 1'b0;
      if (sum_valid) begin
        if (cnt_q == '0)
          len_d = cur_len;
        if (is_last) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (slot_free) begin
            out_d   = add_val;
            aovf_d  = batch_ovf;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          acc_d = add_val;
          cnt_d = cnt_q + BATCH_W'(1);
          ovf_d = batch_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      aovf_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      aovf_q    <= aovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign acc_out      = out_q;
  assign acc_valid    = valid_q;
  assign acc_ovf      = aovf_q;
  assign overrun      = overrun_q;
  assign sample_count = cnt_q;

endmodule
